// File: rtl/spi_master_param.sv
// spi_master_param: SPI master with configurable word width, CPOL/CPHA, bit order,
// clock divider and chip selects. Multi-word frames keep CS asserted between words.
module spi_master_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CS_NUM = 1,
  parameter int unsigned DIV_W  = 8,
  localparam int unsigned CS_W  = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [DIV_W-1:0]  spi_clk_div,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              spi_clk,
  output logic [CS_NUM-1:0] spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned EDGES = 2 * DATA_W;
  localparam int unsigned EW    = $clog2(EDGES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, HOLD, GAP} state_t;

  state_t            state;
  logic [DIV_W-1:0]  h_q;
  logic [DIV_W-1:0]  cnt;
  logic [EW-1:0]     edge_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              cpol_q;
  logic              cpha_q;
  logic              lsb_q;
  logic              last_q;

  logic [DIV_W-1:0]  h_in;
  logic [EW-1:0]     edge_nxt;
  logic              accept;
  logic              cnt_done;
  logic              cpha_eff;
  logic              tx_bit;
  logic              first_bit;
  logic [DATA_W-1:0] tx_sh_nxt;
  logic [DATA_W-1:0] first_sh;
  logic [DATA_W-1:0] rx_sh_nxt;
  logic [CS_NUM-1:0] cs_dec;

  // Handshake, divider, shift-register and chip-select decode helpers
  always_comb begin
    h_in      = (spi_clk_div == '0) ? DIV_W'(1) : spi_clk_div;
    edge_nxt  = edge_cnt + EW'(1);
    accept    = tx_valid && tx_ready && ((state == IDLE) || (state == HOLD));
    cnt_done  = (cnt == h_q - DIV_W'(1));
    cpha_eff  = (state == IDLE) ? cfg_cpha : cpha_q;
    tx_bit    = lsb_q ? tx_sh[0] : tx_sh[DATA_W-1];
    tx_sh_nxt = lsb_q ? {1'b0, tx_sh[DATA_W-1:1]} : {tx_sh[DATA_W-2:0], 1'b0};
    first_bit = cfg_lsb_first ? tx_data[0] : tx_data[DATA_W-1];
    first_sh  = cfg_lsb_first ? {1'b0, tx_data[DATA_W-1:1]} : {tx_data[DATA_W-2:0], 1'b0};
    rx_sh_nxt = lsb_q ? {spi_miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], spi_miso};
    cs_dec    = '1;
    for (int unsigned i = 0; i < CS_NUM; i++) begin
      cs_dec[i] = (cs_sel != CS_W'(i));
    end
  end

  // Transfer FSM; every output is registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      spi_cs_n <= '1;
      spi_clk  <= cfg_cpol;
      spi_mosi <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
      tx_ready <= 1'b0;
      cnt      <= '0;
      edge_cnt <= '0;
      h_q      <= DIV_W'(1);
      tx_sh    <= '0;
      rx_sh    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          spi_clk  <= cfg_cpol;
          spi_mosi <= 1'b0;
          tx_ready <= 1'b1;
          if (accept) begin
            cpol_q   <= cfg_cpol;
            cpha_q   <= cfg_cpha;
            spi_cs_n <= cs_dec;
          end
        end
        SETUP, SHIFT: begin
          if (!cnt_done) begin
            cnt <= cnt + DIV_W'(1);
          end else if ((state == SHIFT) && (edge_cnt == EW'(EDGES))) begin
            state    <= DONE;
            rx_valid <= 1'b1;
            rx_data  <= rx_sh;
            cnt      <= '0;
          end else begin
            state    <= SHIFT;
            cnt      <= '0;
            spi_clk  <= ~spi_clk;
            edge_cnt <= edge_nxt;
            // Sampling edges alternate with launch edges; CPHA picks which comes first
            if (edge_nxt[0] != cpha_q) begin
              rx_sh <= rx_sh_nxt;
            end else if (cpha_q || (edge_nxt != EW'(EDGES))) begin
              spi_mosi <= tx_bit;
              tx_sh    <= tx_sh_nxt;
            end
          end
        end
        DONE: begin
          cnt <= '0;
          if (last_q) begin
            state    <= GAP;
            spi_cs_n <= '1;
            spi_mosi <= 1'b0;
          end else begin
            state    <= HOLD;
            tx_ready <= 1'b1;
          end
        end
        HOLD: begin
          spi_clk <= cpol_q;
        end
        GAP: begin
          if (cnt_done) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Word accept (IDLE or HOLD) overrides the per-state assignments above
      if (accept) begin
        state    <= SETUP;
        busy     <= 1'b1;
        tx_ready <= 1'b0;
        h_q      <= h_in;
        lsb_q    <= cfg_lsb_first;
        last_q   <= tx_last;
        cnt      <= '0;
        edge_cnt <= '0;
        rx_sh    <= '0;
        if (cpha_eff) begin
          tx_sh <= tx_data;
        end else begin
          spi_mosi <= first_bit;
          tx_sh    <= first_sh;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed testbench for spi_master_param: 8-bit/4-CS instance and 16-bit/1-CS instance.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  // 8-bit, 4 chip-select instance
  logic       cpol8, cpha8, lsb8;
  logic [7:0] div8;
  logic [1:0] cs_sel8;
  logic       tx_valid8, tx_ready8, tx_last8, rx_valid8, busy8, sclk8, mosi8, miso8;
  logic [7:0] tx_data8, rx_data8;
  logic [3:0] cs_n8;
  logic       loop8, miso_val8;
  assign miso8 = loop8 ? mosi8 : miso_val8;

  // 16-bit, single chip-select instance
  logic        cpol16, cpha16, lsb16;
  logic [7:0]  div16;
  logic        cs_sel16;
  logic        tx_valid16, tx_ready16, tx_last16, rx_valid16, busy16, sclk16, mosi16, miso16;
  logic [15:0] tx_data16, rx_data16;
  logic        cs_n16;
  assign miso16 = mosi16;

  spi_master_param #(.DATA_W(8), .CS_NUM(4), .DIV_W(8)) dut8 (
    .clk(clk), .rst(rst), .cfg_cpol(cpol8), .cfg_cpha(cpha8), .cfg_lsb_first(lsb8),
    .spi_clk_div(div8), .cs_sel(cs_sel8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
    .tx_data(tx_data8), .tx_last(tx_last8), .rx_valid(rx_valid8), .rx_data(rx_data8),
    .busy(busy8), .spi_clk(sclk8), .spi_cs_n(cs_n8), .spi_mosi(mosi8), .spi_miso(miso8)
  );

  spi_master_param #(.DATA_W(16), .CS_NUM(1), .DIV_W(8)) dut16 (
    .clk(clk), .rst(rst), .cfg_cpol(cpol16), .cfg_cpha(cpha16), .cfg_lsb_first(lsb16),
    .spi_clk_div(div16), .cs_sel(cs_sel16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
    .tx_data(tx_data16), .tx_last(tx_last16), .rx_valid(rx_valid16), .rx_data(rx_data16),
    .busy(busy16), .spi_clk(sclk16), .spi_cs_n(cs_n16), .spi_mosi(mosi16), .spi_miso(miso16)
  );

  task automatic test_reset();
    rst = 1'b1;
    cpol8 = 1'b1;
    @(posedge clk); #1;
    checks++; if (sclk8 !== 1'b1) begin errors++; $display("FAIL reset_sclk_cpol1: got %b expected 1", sclk8); end
    cpol8 = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (cs_n8 !== 4'b1111) begin errors++; $display("FAIL reset_cs_n: got %b expected 1111", cs_n8); end
    checks++; if (sclk8 !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk8); end
    checks++; if (mosi8 !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi8); end
    checks++; if (rx_valid8 !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid8); end
    checks++; if (rx_data8 !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy8); end
    checks++; if (tx_ready8 !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready8); end
    checks++; if (cs_n16 !== 1'b1) begin errors++; $display("FAIL reset_cs_n16: got %b expected 1", cs_n16); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (tx_ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b expected 1", tx_ready8); end
  endtask

  task automatic test_mode0();
    int edges, first_edge, last_edge, rv_n, cs_hi_n, rdy_n, pulses;
    logic prev;
    cpol8 = 0; cpha8 = 0; lsb8 = 0; div8 = 8'd2; cs_sel8 = 2'd0; loop8 = 1;
    for (int i = 0; i < 50 && tx_ready8 !== 1'b1; i++) begin @(posedge clk); #1; end
    checks++; if (tx_ready8 !== 1'b1) begin errors++; $display("FAIL mode0_ready_wait: got %b expected 1", tx_ready8); end
    tx_data8 = 8'hA5; tx_last8 = 1; tx_valid8 = 1;
    @(posedge clk); #1;
    tx_valid8 = 0;
    checks++; if (cs_n8 !== 4'b1110) begin errors++; $display("FAIL mode0_cs_low: got %b expected 1110", cs_n8); end
    checks++; if (mosi8 !== 1'b1) begin errors++; $display("FAIL mode0_first_mosi: got %b expected 1", mosi8); end
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL mode0_busy: got %b expected 1", busy8); end
    edges = 0; first_edge = -1; last_edge = -1; rv_n = -1; cs_hi_n = -1; rdy_n = -1; pulses = 0;
    prev = sclk8;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (sclk8 !== prev) begin edges++; if (first_edge < 0) first_edge = n; last_edge = n; prev = sclk8; end
      if (rx_valid8 === 1'b1) begin pulses++; if (rv_n < 0) rv_n = n; end
      if (cs_n8 === 4'b1111 && cs_hi_n < 0) cs_hi_n = n;
      if (tx_ready8 === 1'b1 && rdy_n < 0) rdy_n = n;
    end
    checks++; if (edges != 16) begin errors++; $display("FAIL mode0_edges: got %0d expected 16", edges); end
    checks++; if (first_edge != 2) begin errors++; $display("FAIL mode0_first_edge: got %0d expected 2", first_edge); end
    checks++; if (last_edge != 32) begin errors++; $display("FAIL mode0_last_edge: got %0d expected 32", last_edge); end
    checks++; if (rv_n != 34) begin errors++; $display("FAIL mode0_rx_valid_time: got %0d expected 34", rv_n); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL mode0_rx_pulses: got %0d expected 1", pulses); end
    checks++; if (rx_data8 !== 8'hA5) begin errors++; $display("FAIL mode0_rx_data_hold: got %h expected a5", rx_data8); end
    checks++; if (cs_hi_n != 35) begin errors++; $display("FAIL mode0_cs_release: got %0d expected 35", cs_hi_n); end
    checks++; if (rdy_n != 37) begin errors++; $display("FAIL mode0_ready_again: got %0d expected 37", rdy_n); end
  endtask

  task automatic test_mode3_lsb();
    cpol8 = 1; cpha8 = 1; lsb8 = 1; div8 = 8'd1; cs_sel8 = 2'd0; loop8 = 0; miso_val8 = 1;
    for (int i = 0; i < 50 && tx_ready8 !== 1'b1; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    checks++; if (sclk8 !== 1'b1) begin errors++; $display("FAIL mode3_idle_high: got %b expected 1", sclk8); end
    tx_data8 = 8'h01; tx_last8 = 1; tx_valid8 = 1;
    @(posedge clk); #1;
    tx_valid8 = 0;
    checks++; if (mosi8 !== 1'b0) begin errors++; $display("FAIL mode3_mosi_before_edge: got %b expected 0", mosi8); end
    checks++; if (sclk8 !== 1'b1) begin errors++; $display("FAIL mode3_setup_clk: got %b expected 1", sclk8); end
    @(posedge clk); #1;
    checks++; if (sclk8 !== 1'b0) begin errors++; $display("FAIL mode3_edge1: got %b expected 0", sclk8); end
    checks++; if (mosi8 !== 1'b1) begin errors++; $display("FAIL mode3_first_mosi: got %b expected 1", mosi8); end
    for (int i = 0; i < 40 && rx_valid8 !== 1'b1; i++) begin @(posedge clk); #1; end
    checks++; if (rx_valid8 !== 1'b1) begin errors++; $display("FAIL mode3_rx_valid: got %b expected 1", rx_valid8); end
    checks++; if (rx_data8 !== 8'hFF) begin errors++; $display("FAIL mode3_rx_data: got %h expected ff", rx_data8); end
    for (int i = 0; i < 20 && tx_ready8 !== 1'b1; i++) begin @(posedge clk); #1; end
    checks++; if (sclk8 !== 1'b1) begin errors++; $display("FAIL mode3_rest_high: got %b expected 1", sclk8); end
  endtask

  task automatic test_two_words();
    int glitch, busy_drop, pulses, n;
    logic sent2;
    logic [7:0] rx1, rx2;
    cpol8 = 0; cpha8 = 0; lsb8 = 0; div8 = 8'd1; cs_sel8 = 2'd2; loop8 = 1; miso_val8 = 0;
    for (int i = 0; i < 50 && tx_ready8 !== 1'b1; i++) begin @(posedge clk); #1; end
    tx_data8 = 8'h12; tx_last8 = 0; tx_valid8 = 1;
    @(posedge clk); #1;
    tx_valid8 = 0;
    glitch = 0; busy_drop = 0; pulses = 0; n = 0; sent2 = 0; rx1 = '0; rx2 = '0;
    while (cs_n8 !== 4'b1111 && n < 200) begin
      if (cs_n8 !== 4'b1011) glitch++;
      if (busy8 !== 1'b1) busy_drop++;
      if (rx_valid8 === 1'b1) begin if (pulses == 0) rx1 = rx_data8; else rx2 = rx_data8; pulses++; end
      if (tx_valid8) tx_valid8 = 0;
      else if (!sent2 && tx_ready8 === 1'b1) begin tx_data8 = 8'h34; tx_last8 = 1; tx_valid8 = 1; sent2 = 1; end
      @(posedge clk); #1;
      n++;
    end
    checks++; if (cs_n8 !== 4'b1111) begin errors++; $display("FAIL two_cs_release: got %b expected 1111", cs_n8); end
    checks++; if (sent2 !== 1'b1) begin errors++; $display("FAIL two_second_sent: got %b expected 1", sent2); end
    checks++; if (glitch != 0) begin errors++; $display("FAIL two_cs_glitch: got %0d expected 0", glitch); end
    checks++; if (busy_drop != 0) begin errors++; $display("FAIL two_busy_drop: got %0d expected 0", busy_drop); end
    checks++; if (pulses != 2) begin errors++; $display("FAIL two_rx_pulses: got %0d expected 2", pulses); end
    checks++; if (rx1 !== 8'h12) begin errors++; $display("FAIL two_rx1: got %h expected 12", rx1); end
    checks++; if (rx2 !== 8'h34) begin errors++; $display("FAIL two_rx2: got %h expected 34", rx2); end
  endtask

  task automatic test_reset_abort();
    int edges, n, bad_rv, bad_cs;
    logic prev;
    cpol8 = 0; cpha8 = 0; lsb8 = 0; div8 = 8'd2; cs_sel8 = 2'd1; loop8 = 1;
    for (int i = 0; i < 50 && tx_ready8 !== 1'b1; i++) begin @(posedge clk); #1; end
    tx_data8 = 8'h5A; tx_last8 = 1; tx_valid8 = 1;
    @(posedge clk); #1;
    tx_valid8 = 0;
    edges = 0; n = 0; prev = sclk8;
    while (edges < 7 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (sclk8 !== prev) begin edges++; prev = sclk8; end
    end
    checks++; if (edges != 7) begin errors++; $display("FAIL abort_reach_edge7: got %0d expected 7", edges); end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++; if (cs_n8 !== 4'b1111) begin errors++; $display("FAIL abort_cs: got %b expected 1111", cs_n8); end
    checks++; if (sclk8 !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b expected 0", sclk8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy8); end
    bad_rv = 0; bad_cs = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rx_valid8 !== 1'b0) bad_rv++;
      if (cs_n8 !== 4'b1111) bad_cs++;
    end
    checks++; if (bad_rv != 0) begin errors++; $display("FAIL abort_no_rx_valid: got %0d expected 0", bad_rv); end
    checks++; if (bad_cs != 0) begin errors++; $display("FAIL abort_no_cs_glitch: got %0d expected 0", bad_cs); end
    tx_data8 = 8'hC3; tx_last8 = 1; tx_valid8 = 1;
    @(posedge clk); #1;
    tx_valid8 = 0;
    for (int i = 0; i < 60 && rx_valid8 !== 1'b1; i++) begin @(posedge clk); #1; end
    checks++; if (rx_valid8 !== 1'b1) begin errors++; $display("FAIL abort_recover_valid: got %b expected 1", rx_valid8); end
    checks++; if (rx_data8 !== 8'hC3) begin errors++; $display("FAIL abort_recover_data: got %h expected c3", rx_data8); end
  endtask

  task automatic test_div0_16();
    int edges, first_edge, rv_n;
    logic prev;
    cpol16 = 0; cpha16 = 0; lsb16 = 0; div16 = 8'd0; cs_sel16 = 1'b0;
    for (int i = 0; i < 50 && tx_ready16 !== 1'b1; i++) begin @(posedge clk); #1; end
    tx_data16 = 16'hBEEF; tx_last16 = 1; tx_valid16 = 1;
    @(posedge clk); #1;
    tx_valid16 = 0;
    checks++; if (cs_n16 !== 1'b0) begin errors++; $display("FAIL div0_cs_low: got %b expected 0", cs_n16); end
    edges = 0; first_edge = -1; rv_n = -1; prev = sclk16;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (sclk16 !== prev) begin edges++; if (first_edge < 0) first_edge = n; prev = sclk16; end
      if (rx_valid16 === 1'b1 && rv_n < 0) rv_n = n;
    end
    checks++; if (edges != 32) begin errors++; $display("FAIL div0_edges: got %0d expected 32", edges); end
    checks++; if (first_edge != 1) begin errors++; $display("FAIL div0_first_edge: got %0d expected 1", first_edge); end
    checks++; if (rv_n != 33) begin errors++; $display("FAIL div0_rx_valid_time: got %0d expected 33", rv_n); end
    checks++; if (rx_data16 !== 16'hBEEF) begin errors++; $display("FAIL div0_rx_data: got %h expected beef", rx_data16); end
  endtask

  task automatic test_cs_out_of_range();
    int cs_low;
    cpol16 = 0; cpha16 = 0; lsb16 = 1; div16 = 8'd1; cs_sel16 = 1'b1;
    for (int i = 0; i < 50 && tx_ready16 !== 1'b1; i++) begin @(posedge clk); #1; end
    tx_data16 = 16'h000F; tx_last16 = 1; tx_valid16 = 1;
    @(posedge clk); #1;
    tx_valid16 = 0;
    cs_low = 0;
    for (int i = 0; i < 60 && rx_valid16 !== 1'b1; i++) begin
      if (cs_n16 !== 1'b1) cs_low++;
      @(posedge clk); #1;
    end
    checks++; if (cs_low != 0) begin errors++; $display("FAIL oor_cs_stays_high: got %0d expected 0", cs_low); end
    checks++; if (rx_valid16 !== 1'b1) begin errors++; $display("FAIL oor_rx_valid: got %b expected 1", rx_valid16); end
    checks++; if (rx_data16 !== 16'h000F) begin errors++; $display("FAIL oor_rx_data: got %h expected 000f", rx_data16); end
  endtask

  task automatic test_busy_ignore();
    int n, rdy_hi;
    cpol8 = 0; cpha8 = 0; lsb8 = 0; div8 = 8'd1; cs_sel8 = 2'd0; loop8 = 1;
    for (int i = 0; i < 50 && tx_ready8 !== 1'b1; i++) begin @(posedge clk); #1; end
    tx_data8 = 8'h3C; tx_last8 = 1; tx_valid8 = 1;
    @(posedge clk); #1;
    n = 0; rdy_hi = 0;
    while (rx_valid8 !== 1'b1 && n < 60) begin
      tx_data8 = 8'(8'h81 + n * 29);
      if (tx_ready8 === 1'b1) rdy_hi++;
      @(posedge clk); #1;
      n++;
    end
    tx_valid8 = 0;
    checks++; if (rx_valid8 !== 1'b1) begin errors++; $display("FAIL ignore_rx_valid: got %b expected 1", rx_valid8); end
    checks++; if (rdy_hi != 0) begin errors++; $display("FAIL ignore_ready_low: got %0d expected 0", rdy_hi); end
    checks++; if (rx_data8 !== 8'h3C) begin errors++; $display("FAIL ignore_word_intact: got %h expected 3c", rx_data8); end
    repeat (5) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    cpol8 = 0; cpha8 = 0; lsb8 = 0; div8 = 8'd1; cs_sel8 = '0;
    tx_valid8 = 0; tx_data8 = '0; tx_last8 = 0; loop8 = 1; miso_val8 = 0;
    cpol16 = 0; cpha16 = 0; lsb16 = 0; div16 = 8'd1; cs_sel16 = 1'b0;
    tx_valid16 = 0; tx_data16 = '0; tx_last16 = 0;
    test_reset();
    test_mode0();
    test_mode3_lsb();
    test_two_words();
    test_reset_abort();
    test_div0_16();
    test_cs_out_of_range();
    test_busy_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
